bp_me_stream_gather: RTL and testbench
======================================

BP_ME_STREAM_GATHER -- requirements
Module: bp_me_stream_gather

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, selecting the processor configuration for paddr/lce widths.
REQ-002 SHALL have parameter stream_data_width_p, default dword_width_p, giving the width of one stream beat.
REQ-003 SHALL have parameter block_width_p, default cce_block_width_p, giving the width of the assembled block; stream_words = block_width_p/stream_data_width_p.
REQ-004 SHALL have parameter payload_mask_p, default 0, a bitmask over msg_type marking message types that carry data.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_header_i, input, xce mem header width at stream_data_width_p: per-beat header.
REQ-008 SHALL have port in_data_i, input, stream_data_width_p: beat data.
REQ-009 SHALL have ports in_v_i and in_lock_i, inputs, 1 bit each: beat valid; lock=1 means more beats follow.
REQ-010 SHALL have port in_yumi_o, output, 1 bit: beat consumed.
REQ-011 SHALL have port out_header_o, output, xce mem header width at block_width_p: assembled header.
REQ-012 SHALL have port out_data_o, output, block_width_p: assembled block.
REQ-013 SHALL have ports out_v_o (output, 1) and out_ready_and_i (input, 1): ready-valid handshake.
REQ-014 SHALL have port error_o, output, 1 bit: sticky overflow flag.

Function
REQ-015 SHALL implement states e_ready, e_gather and e_out.
REQ-016 In e_ready or e_gather, in_yumi_o SHALL equal in_v_i; in e_out, in_yumi_o SHALL be 0.
REQ-017 The first accepted beat in e_ready SHALL latch its header, with addr, msg_type, size and payload copied unchanged; beat count SHALL be set to 1.
REQ-018 Beat k (0-based, counted in arrival order) SHALL be written to data word k.
REQ-019 A beat accepted with in_lock_i=1 SHALL move or keep the state in e_gather; a beat with in_lock_i=0 SHALL move the state to e_out.
REQ-020 A single-beat message (lock=0 on the first beat), or any message whose type is not in payload_mask_p, SHALL replicate beat data across all stream_words words.
REQ-021 out_v_o SHALL assert in the cycle after the last beat is accepted; latency from last yumi to out_v_o SHALL be 1 cycle.
REQ-022 out_header_o and out_data_o SHALL be stable while out_v_o=1.
REQ-023 out_v_o & out_ready_and_i SHALL return the state to e_ready; the next beat SHALL be accepted no earlier than the following cycle.
REQ-024 Overflow: if a locked beat arrives when beat count equals stream_words, the beat SHALL be consumed, SHALL overwrite word stream_words-1, and error_o SHALL set.
REQ-025 The beat counter SHALL saturate at stream_words and SHALL NOT wrap.
REQ-026 Headers of beats after the first SHALL be ignored, apart from the lock bit.

Reset
REQ-027 Asserting reset_n_i low SHALL force state e_ready, out_v_o=0, error_o=0 and beat count=0, regardless of the clock.
REQ-028 Reset asserted mid-message SHALL discard partial data; out_data_o and out_header_o need not be reset.

Structure
REQ-029 State enum and bp_bedrock mem header typedefs SHALL live in bp_me_pkg.
REQ-030 stream_words SHALL be a localparam derived in-module.
REQ-031 The word counter SHALL be one sub-module: bsg_counter_clear_up.

Verification
REQ-032 Bench SHALL cover: 64B write as 8x64b beats, lock=1 on beats 0-6 -> out_v_o one cycle after beat 7; words 0..7 = beats 0..7; header addr = beat-0 addr.
REQ-033 Bench SHALL cover: 8B uc_rd, single beat, lock=0, mask bit clear -> out_data_o = data replicated 8x; out_v_o next cycle.
REQ-034 Bench SHALL cover: out_ready_and_i held 0 for 5 cycles with in_v_i=1 -> in_yumi_o=0, outputs stable; on ready, state returns to e_ready and the next beat is accepted the following cycle.
REQ-035 Bench SHALL cover: 9 beats with lock=1 on the first 8 -> error_o=1 from the 9th beat onward; word 7 = beat 8.
REQ-036 Bench SHALL cover: reset_n_i pulsed low after beat 3 of 8 -> out_v_o=0 immediately; next message assembles from word 0.
REQ-037 Bench SHALL cover: back-to-back 2-beat messages with ready tied high -> one output per 3 cycles, with no beat dropped.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared BedRock memory header types, processor configuration selector and
// gather FSM states used by the ME stream blocks.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  localparam int dword_width_p     = 64;
  localparam int cce_block_width_p = 512;
  localparam int paddr_width_p     = 40;
  localparam int lce_id_width_p    = 8;
  localparam int way_id_width_p    = 3;
  localparam int mem_type_count_lp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_id_width_p-1:0] way_id;
    logic                      prefetch;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s  payload;
    bp_bedrock_msg_size_e     size;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_gather = 2'd1,
    e_out    = 2'd2
  } bp_me_gather_state_e;

  // Header carries the widest address; smaller configs use only the low bits.
  function automatic int bp_paddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 32;
      default:        return paddr_width_p;
    endcase
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Saturating up counter with synchronous clear; clear and up together load 1.
module bsg_counter_clear_up
  #(parameter int max_val_p = 8
   ,parameter int width_p   = $clog2(max_val_p + 1)
   )
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               clear_i
  ,input  logic               up_i
  ,output logic [width_p-1:0] count_o
  );

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= up_i ? width_p'(1) : '0;
    end else if (up_i && (count_r != max_lp)) begin
      count_r <= count_r + width_p'(1);
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_me_stream_gather.sv
// Gathers a locked stream of narrow beats into one block-wide message and
// presents it on a ready/valid output; flags beats beyond the block as overflow.
module bp_me_stream_gather
  import bp_me_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,parameter int stream_data_width_p = dword_width_p
   ,parameter int block_width_p       = cce_block_width_p
   ,parameter logic [mem_type_count_lp-1:0] payload_mask_p = '0
   )
  (input  logic                           clk_i
  ,input  logic                           reset_n_i
  ,input  bp_bedrock_mem_header_s         in_header_i
  ,input  logic [stream_data_width_p-1:0] in_data_i
  ,input  logic                           in_v_i
  ,input  logic                           in_lock_i
  ,output logic                           in_yumi_o
  ,output bp_bedrock_mem_header_s         out_header_o
  ,output logic [block_width_p-1:0]       out_data_o
  ,output logic                           out_v_o
  ,input  logic                           out_ready_and_i
  ,output logic                           error_o
  );

  localparam int stream_words_lp = block_width_p / stream_data_width_p;
  localparam int count_width_lp  = $clog2(stream_words_lp + 1);
  localparam int idx_width_lp    = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(stream_words_lp);
  localparam logic [idx_width_lp-1:0]   last_idx_lp   = idx_width_lp'(stream_words_lp - 1);
  localparam logic [paddr_width_p-1:0]  addr_mask_lp  =
    {paddr_width_p{1'b1}} >> (paddr_width_p - bp_paddr_width(bp_params_p));

  bp_me_gather_state_e         state_r;
  bp_bedrock_mem_header_s      header_r;
  logic [block_width_p-1:0]    data_r;
  logic                        out_v_r;
  logic                        error_r;
  logic [count_width_lp-1:0]   count;
  logic [idx_width_lp-1:0]     wr_idx;
  bp_bedrock_mem_type_e        cur_type;
  logic                        accept, first_beat, replicate, overflow;

  assign accept     = in_v_i & (state_r != e_out);
  assign first_beat = accept & (state_r == e_ready);
  assign overflow   = accept & (state_r == e_gather) & (count == full_count_lp);
  assign cur_type   = (state_r == e_ready) ? in_header_i.msg_type : header_r.msg_type;
  assign replicate  = (first_beat & ~in_lock_i) | ~payload_mask_p[cur_type];

  bsg_counter_clear_up
    #(.max_val_p(stream_words_lp)
     ,.width_p  (count_width_lp)
     )
    word_counter
     (.clk_i    (clk_i)
     ,.reset_n_i(reset_n_i)
     ,.clear_i  (first_beat)
     ,.up_i     (accept)
     ,.count_o  (count)
     );

  // Once the block is full, further beats keep landing in the last word.
  always_comb begin
    wr_idx = '0;
    if (state_r == e_gather) begin
      wr_idx = (count == full_count_lp) ? last_idx_lp : idx_width_lp'(count);
    end
  end

  always_ff @(posedge clk_i) begin
    if (first_beat) begin
      header_r      <= in_header_i;
      header_r.addr <= in_header_i.addr & addr_mask_lp;
    end
    if (accept) begin
      for (int w = 0; w < stream_words_lp; w++) begin
        if (replicate || (wr_idx == idx_width_lp'(w))) begin
          data_r[w*stream_data_width_p +: stream_data_width_p] <= in_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      out_v_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        e_ready, e_gather: begin
          if (accept) begin
            state_r <= in_lock_i ? e_gather : e_out;
            out_v_r <= ~in_lock_i;
          end
        end
        e_out: begin
          if (out_ready_and_i) begin
            state_r <= e_ready;
            out_v_r <= 1'b0;
          end
        end
        default: begin
          state_r <= e_ready;
          out_v_r <= 1'b0;
        end
      endcase
      if (overflow) begin
        error_r <= 1'b1;
      end
    end
  end

  assign in_yumi_o    = accept;
  assign out_header_o = header_r;
  assign out_data_o   = data_r;
  assign out_v_o      = out_v_r;
  assign error_o      = error_r;

endmodule

// File: tb/tb_bp_me_stream_gather.sv
// Randomized self-checking bench for bp_me_stream_gather against a
// message-level reference model and output scoreboard.
module tb_bp_me_stream_gather;
  import bp_me_pkg::*;

  localparam int beat_w  = 64;
  localparam int block_w = 512;
  localparam int words   = block_w / beat_w;
  localparam logic [15:0] tb_payload_mask = 16'h000A;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  bp_bedrock_mem_header_s in_header;
  logic [beat_w-1:0]      in_data;
  logic                   in_v = 1'b0;
  logic                   in_lock = 1'b0;
  logic                   in_yumi;
  bp_bedrock_mem_header_s out_header;
  logic [block_w-1:0]     out_data;
  logic                   out_v;
  logic                   out_ready = 1'b1;
  logic                   error;

  typedef struct {
    bp_bedrock_mem_header_s hdr;
    logic [block_w-1:0]     data;
    logic [block_w-1:0]     care;
    logic                   err;
  } expect_t;

  expect_t                exp_q[$];
  bp_bedrock_mem_header_s cur_hdr[$];
  logic [beat_w-1:0]      cur_data[$];
  int                     hs_cycles[$];
  int                     checks = 0;
  int                     errors = 0;
  int                     cycle = 0;
  bit                     exp_err = 1'b0;
  bit                     rand_ready = 1'b0;
  bit                     hold_v = 1'b0;
  bp_bedrock_mem_header_s prev_hdr;
  logic [block_w-1:0]     prev_data;

  bp_me_stream_gather
    #(.bp_params_p        (e_bp_default_cfg)
     ,.stream_data_width_p(beat_w)
     ,.block_width_p      (block_w)
     ,.payload_mask_p     (tb_payload_mask)
     )
    dut
     (.clk_i          (clk)
     ,.reset_n_i      (reset_n)
     ,.in_header_i    (in_header)
     ,.in_data_i      (in_data)
     ,.in_v_i         (in_v)
     ,.in_lock_i      (in_lock)
     ,.in_yumi_o      (in_yumi)
     ,.out_header_o   (out_header)
     ,.out_data_o     (out_data)
     ,.out_v_o        (out_v)
     ,.out_ready_and_i(out_ready)
     ,.error_o        (error)
     );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [block_w-1:0] obs,
                             input logic [block_w-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isPayload(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
  endfunction

  function automatic bp_bedrock_mem_type_e randomType();
    logic [3:0] v;
    v = 4'($urandom_range(0, 5));
    return bp_bedrock_mem_type_e'(v);
  endfunction

  function automatic bp_bedrock_mem_header_s mkHeader(input bp_bedrock_mem_type_e t);
    bp_bedrock_mem_header_s h;
    logic [63:0] r;
    r = {$urandom, $urandom};
    h.msg_type         = t;
    h.addr             = r[paddr_width_p-1:0];
    h.size             = bp_bedrock_msg_size_e'(r[42:40]);
    h.payload.lce_id   = r[50:43];
    h.payload.way_id   = r[53:51];
    h.payload.prefetch = r[54];
    return h;
  endfunction

  // Model: whole-message view of the block the gather should produce.
  task automatic prepareMessage(input bp_bedrock_mem_type_e t, input int nbeats);
    expect_t e;
    logic [beat_w-1:0] d;
    int idx;
    bit rep;
    cur_hdr.delete();
    cur_data.delete();
    e.hdr  = mkHeader(t);
    e.data = '0;
    e.care = '0;
    rep = (nbeats == 1) || !isPayload(t);
    for (int k = 0; k < nbeats; k++) begin
      d = {$urandom, $urandom};
      cur_data.push_back(d);
      cur_hdr.push_back((k == 0) ? e.hdr : mkHeader(randomType()));
      if (rep) begin
        for (int w = 0; w < words; w++) e.data[w*beat_w +: beat_w] = d;
        e.care = '1;
      end else begin
        idx = (k < words) ? k : words - 1;
        e.data[idx*beat_w +: beat_w] = d;
        e.care[idx*beat_w +: beat_w] = '1;
      end
    end
    if (nbeats > words) exp_err = 1'b1;
    e.err = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bp_bedrock_mem_header_s h, input logic [beat_w-1:0] d,
                               input logic lock);
    int waits = 0;
    in_header = h;
    in_data   = d;
    in_lock   = lock;
    in_v      = 1'b1;
    #1;
    while (!in_yumi && waits < 50) begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      waits++;
    end
    if (!in_yumi) checkOutput("yumi_timeout", 0, 1);
    @(posedge clk);
    #2;
    in_v = 1'b0;
    #1;
  endtask

  task automatic sendMessage(input bp_bedrock_mem_type_e t, input int nbeats);
    bit err_before;
    err_before = exp_err;
    prepareMessage(t, nbeats);
    for (int k = 0; k < nbeats; k++) begin
      applyStimulus(cur_hdr[k], cur_data[k], (k != nbeats - 1));
      checkOutput("out_v_after_beat", out_v, (k == nbeats - 1));
      checkOutput("error_after_beat", error, err_before | (k >= words));
    end
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    expect_t e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checkOutput("hold_v", out_v, 1);
        checkOutput("hold_header", out_header, prev_hdr);
        checkOutput("hold_data", out_data, prev_data);
      end
      if (in_yumi) checkOutput("yumi_with_v", out_v, 0);
      if (out_v && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_header", out_header, e.hdr);
          checkOutput("out_data", out_data & e.care, e.data & e.care);
          checkOutput("out_error", error, e.err);
        end
        hs_cycles.push_back(cycle);
        hold_v = 1'b0;
      end else if (out_v) begin
        hold_v    = 1'b1;
        prev_hdr  = out_header;
        prev_data = out_data;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    in_header = '0;
    in_data   = '0;

    #12;
    checkOutput("reset_out_v", out_v, 0);
    checkOutput("reset_error", error, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;

    // Full 64B write: eight beats, word k holds beat k.
    sendMessage(e_bedrock_mem_wr, 8);
    // Uncached 8B read: single beat replicated across the block.
    sendMessage(e_bedrock_mem_uc_rd, 1);
    drain();

    // Output stall with a beat waiting at the input.
    out_ready = 1'b0;
    sendMessage(e_bedrock_mem_uc_rd, 1);
    prepareMessage(e_bedrock_mem_uc_rd, 1);
    in_header = cur_hdr[0];
    in_data   = cur_data[0];
    in_lock   = 1'b0;
    in_v      = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_yumi", in_yumi, 0);
      checkOutput("stall_out_v", out_v, 1);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("ready_cycle_yumi", in_yumi, 0);
    @(posedge clk);
    #2;
    checkOutput("after_hs_out_v", out_v, 0);
    checkOutput("after_hs_yumi", in_yumi, 1);
    @(posedge clk);
    #2;
    in_v = 1'b0;
    #1;
    checkOutput("next_msg_out_v", out_v, 1);
    drain();

    // Overflow: nine locked-then-unlocked beats.
    sendMessage(e_bedrock_mem_wr, 9);
    drain();
    checkOutput("error_sticky", error, 1);

    // Reset in the middle of a message.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mkHeader(e_bedrock_mem_wr), {$urandom, $urandom}, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_v", out_v, 0);
    checkOutput("midrst_error", error, 0);
    exp_err = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    sendMessage(e_bedrock_mem_wr, 8);
    drain();

    // Back-to-back two-beat messages with ready held high.
    hs_cycles.delete();
    for (int m = 0; m < 4; m++) sendMessage(e_bedrock_mem_wr, 2);
    drain();
    checkOutput("b2b_count", hs_cycles.size(), 4);
    for (int i = 1; i < hs_cycles.size(); i++) begin
      checkOutput("b2b_spacing", hs_cycles[i] - hs_cycles[i-1], 3);
    end

    // Randomized traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int m = 0; m < 30; m++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:       sendMessage(e_bedrock_mem_uc_rd, 1);
        2:          sendMessage(e_bedrock_mem_rd, 1);
        3:          sendMessage(e_bedrock_mem_uc_wr, 1);
        4, 5, 6, 7: sendMessage(e_bedrock_mem_wr, $urandom_range(2, 8));
        8:          sendMessage(e_bedrock_mem_uc_wr, 8);
        default:    sendMessage(e_bedrock_mem_wr, $urandom_range(9, 10));
      endcase
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
